// File: rtl/onchip_ram_pkg.sv
// Shared definitions for the dual-port Avalon-MM on-chip RAM.
//   num_bytes()      : number of byte lanes in a data word
//   RL_UNREG, RL_REG : the two supported read latencies
//   port_e           : index of each slave port (s1, s2)
package onchip_ram_pkg;

  localparam int RL_UNREG = 1;  // readdata straight from the RAM read register
  localparam int RL_REG   = 2;  // one extra output register

  typedef enum logic [0:0] {
    PORT_S1 = 1'b0,
    PORT_S2 = 1'b1
  } port_e;

  function automatic int num_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_read_pipe.sv
// Per-port read return pipeline: READ_LATENCY stages of valid + data.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low clear of all stages
//   in_valid       : a read was accepted this cycle
//   in_data        : word read from the RAM for that read
//   out_valid      : readdatavalid, high for exactly one cycle per read
//   out_data       : readdata, holds its last value while out_valid is low
module onchip_ram_read_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [READ_LATENCY-1:0] valid_r;
  logic [DATA_WIDTH-1:0]   data_r [READ_LATENCY];

  // Shift valid each cycle; data stages only load behind a valid so the
  // last stage keeps the previous word between returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[READ_LATENCY-1];
  assign out_data  = data_r[READ_LATENCY-1];

endmodule

// File: rtl/avalon_onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM (s1, s2) on a single clock, with byte
// enables, readdatavalid/waitrequest handshakes and fixed collision rules:
// a same-address write/write stalls s2 for one cycle, a read colliding with
// a write returns the old word.
// Optional macro ONCHIP_RAM_CLEAR_EN: after reset release, zero every word
// one per cycle and hold init_done low (both ports stalled) until done.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   clken, reset_req    : either one blocks new transfers
//   sN_address/byteenable/chipselect/read/write/writedata : slave N request
//   sN_readdata/readdatavalid/waitrequest                 : slave N response
//   init_done           : memory ready for traffic
module avalon_onchip_ram_dp
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clken,
  input  logic                           reset_req,
  input  logic [ADDR_WIDTH-1:0]          s1_address,
  input  logic [DATA_WIDTH/8-1:0]        s1_byteenable,
  input  logic                           s1_chipselect,
  input  logic                           s1_read,
  input  logic                           s1_write,
  input  logic [DATA_WIDTH-1:0]          s1_writedata,
  output logic [DATA_WIDTH-1:0]          s1_readdata,
  output logic                           s1_readdatavalid,
  output logic                           s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]          s2_address,
  input  logic [DATA_WIDTH/8-1:0]        s2_byteenable,
  input  logic                           s2_chipselect,
  input  logic                           s2_read,
  input  logic                           s2_write,
  input  logic [DATA_WIDTH-1:0]          s2_writedata,
  output logic [DATA_WIDTH-1:0]          s2_readdata,
  output logic                           s2_readdatavalid,
  output logic                           s2_waitrequest,
  output logic                           init_done
);

  localparam int NB = num_bytes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  if ((READ_LATENCY != RL_UNREG) && (READ_LATENCY != RL_REG)) begin : g_bad_latency
    $error("avalon_onchip_ram_dp: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  // Per-port request view, indexed by port_e.
  logic [ADDR_WIDTH-1:0] addr_s  [2];
  logic [NB-1:0]         be_s    [2];
  logic [DATA_WIDTH-1:0] wdata_s [2];
  logic [DATA_WIDTH-1:0] rdata_s [2];
  logic [1:0]            cs_s, rd_s, wr_s;
  logic [1:0]            wait_s, acc_s, acc_wr_s, acc_rd_s, in_range_s;
  logic                  base_stall_s, collision2_s, init_done_s;
  logic                  clr_we_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;

  assign addr_s[PORT_S1]  = s1_address;
  assign addr_s[PORT_S2]  = s2_address;
  assign be_s[PORT_S1]    = s1_byteenable;
  assign be_s[PORT_S2]    = s2_byteenable;
  assign wdata_s[PORT_S1] = s1_writedata;
  assign wdata_s[PORT_S2] = s2_writedata;
  assign cs_s = {s2_chipselect, s1_chipselect};
  assign rd_s = {s2_read, s1_read};
  assign wr_s = {s2_write, s1_write};

`ifdef ONCHIP_RAM_CLEAR_EN
  logic                  init_done_r;
  logic [ADDR_WIDTH-1:0] clr_addr_r;

  // Clear sweep: one word per cycle from address 0; a reset restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done_r <= 1'b0;
      clr_addr_r  <= '0;
    end else if (!init_done_r) begin
      if ({1'b0, clr_addr_r} == (DEPTH_L - (ADDR_WIDTH+1)'(1))) begin
        init_done_r <= 1'b1;
      end else begin
        clr_addr_r <= clr_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign init_done_s = init_done_r;
  assign clr_we_s    = reset_n & ~init_done_r;
  assign clr_addr_s  = clr_addr_r;
`else
  assign init_done_s = 1'b1;
  assign clr_we_s    = 1'b0;
  assign clr_addr_s  = '0;
`endif

  assign init_done = init_done_s;

  // Handshake, collision and acceptance decode; RAM read is combinational
  // so the read register samples the pre-write word at the acceptance edge.
  always_comb begin
    base_stall_s = ~reset_n | ~clken | reset_req | ~init_done_s;
    collision2_s = cs_s[PORT_S1] & wr_s[PORT_S1] & cs_s[PORT_S2] & wr_s[PORT_S2]
                 & (addr_s[PORT_S1] == addr_s[PORT_S2]);
    wait_s          = {2{base_stall_s}};
    wait_s[PORT_S2] = base_stall_s | collision2_s;
    acc_s      = 2'b00;
    acc_wr_s   = 2'b00;
    acc_rd_s   = 2'b00;
    in_range_s = 2'b00;
    for (int p = 0; p < 2; p++) begin
      acc_s[p]      = cs_s[p] & (rd_s[p] | wr_s[p]) & ~wait_s[p];
      acc_wr_s[p]   = acc_s[p] & wr_s[p];
      acc_rd_s[p]   = acc_s[p] & ~wr_s[p];
      in_range_s[p] = ({1'b0, addr_s[p]} < DEPTH_L);
      if (in_range_s[p]) begin
        rdata_s[p] = mem_r[addr_s[p]];
      end else begin
        rdata_s[p] = '0;
      end
    end
  end

  // RAM array write port: clear sweep or byte-lane writes (never both, the
  // sweep holds both ports in waitrequest). Contents are never reset.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (acc_wr_s[p] && in_range_s[p] && be_s[p][b]) begin
            mem_r[addr_s[p]][b*8 +: 8] <= wdata_s[p][b*8 +: 8];
          end
        end
      end
    end
  end

  onchip_ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_s1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (acc_rd_s[PORT_S1]),
    .in_data  (rdata_s[PORT_S1]),
    .out_valid(s1_readdatavalid),
    .out_data (s1_readdata)
  );

  onchip_ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_s2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (acc_rd_s[PORT_S2]),
    .in_data  (rdata_s[PORT_S2]),
    .out_valid(s2_readdatavalid),
    .out_data (s2_readdata)
  );

  assign s1_waitrequest = wait_s[PORT_S1];
  assign s2_waitrequest = wait_s[PORT_S2];

endmodule

// File: tb/tb_avalon_onchip_ram_dp.sv
// Bench for avalon_onchip_ram_dp: two instances (READ_LATENCY 1 and 2,
// DEPTH 1000, ADDR_WIDTH 10) share one stimulus stream; a word-level memory
// model with per-cycle read history predicts every output.
module tb_avalon_onchip_ram_dp;

  localparam int AW    = 10;
  localparam int DEPTH = 1000;
  localparam int NCYC  = 8000;
`ifdef ONCHIP_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clken, reset_req;
  logic          cs [2];
  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] addr [2];
  logic [3:0]    be [2];
  logic [31:0]   wd [2];

  logic [31:0] o_rdata [2][2];   // [dut][port]
  logic        o_rv    [2][2];
  logic        o_wait  [2][2];
  logic        o_init  [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    avalon_onchip_ram_dp #(
      .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(d + 1), .INIT_FILE("")
    ) dut (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_address(addr[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]),
      .s1_read(rd[0]), .s1_write(wr[0]), .s1_writedata(wd[0]),
      .s1_readdata(o_rdata[d][0]), .s1_readdatavalid(o_rv[d][0]), .s1_waitrequest(o_wait[d][0]),
      .s2_address(addr[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]),
      .s2_read(rd[1]), .s2_write(wr[1]), .s2_writedata(wd[1]),
      .s2_readdata(o_rdata[d][1]), .s2_readdatavalid(o_rv[d][1]), .s2_waitrequest(o_wait[d][1]),
      .init_done(o_init[d])
    );
  end

  // Reference model
  logic [31:0] m  [0:DEPTH-1];
  bit          mk [0:DEPTH-1];          // word contents known
  bit          hv [2][0:NCYC-1];        // read accepted in cycle t
  logic [31:0] hd [2][0:NCYC-1];
  bit          hk [2][0:NCYC-1];
  logic [31:0] last_d [2][2];
  bit          last_k [2][2];
  int t = 0, since_rel = 0, n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
      addr[p] = '0; be[p] = 4'h0; wd[p] = 32'h0;
    end
  endtask

  task automatic req(input int p, input bit r, input bit w, input int a,
                     input logic [3:0] b, input logic [31:0] d);
    cs[p] = 1'b1; rd[p] = r; wr[p] = w; addr[p] = AW'(a); be[p] = b; wd[p] = d;
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic step();
    bit init_e, base, col2, v, inr;
    bit w [2];
    bit acc [2];
    int a;
    @(negedge clk);
    if (t >= NCYC - 1) begin
      $display("FAIL cycle_budget t=%0d got=%0d expected=%0d", t, t, NCYC - 1);
      n_bad++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "cycle budget exhausted");
    end
    if (!reset_n) begin
      for (int p = 0; p < 2; p++)
        for (int k = 1; k <= 3; k++)
          if (t - k >= 0) hv[p][t-k] = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          last_d[d][p] = 32'h0; last_k[d][p] = 1'b1;
        end
      since_rel = 0;
    end
    init_e = CLR ? (since_rel >= DEPTH) : 1'b1;
    base   = !reset_n || !clken || reset_req || !init_e;
    col2   = cs[0] && wr[0] && cs[1] && wr[1] && (addr[0] == addr[1]);
    w[0] = base;
    w[1] = base || col2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("init_done_d%0d", d), 32'(o_init[d]), 32'(init_e));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("waitrequest_d%0d_s%0d", d, p + 1), 32'(o_wait[d][p]), 32'(w[p]));
        v = (t >= d + 1) && hv[p][t-d-1];
        if (v) begin
          last_d[d][p] = hd[p][t-d-1];
          last_k[d][p] = hk[p][t-d-1];
        end
        check($sformatf("readdatavalid_d%0d_s%0d", d, p + 1), 32'(o_rv[d][p]), 32'(v));
        if (last_k[d][p])
          check($sformatf("readdata_d%0d_s%0d", d, p + 1), o_rdata[d][p], last_d[d][p]);
      end
    end
    // Reads see the memory before this edge's writes.
    for (int p = 0; p < 2; p++) begin
      acc[p] = cs[p] && (rd[p] || wr[p]) && !w[p];
      hv[p][t] = acc[p] && !wr[p];
      a   = int'(addr[p]);
      inr = a < DEPTH;
      hd[p][t] = inr ? m[a] : 32'h0;
      hk[p][t] = inr ? mk[a] : 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      a = int'(addr[p]);
      if (acc[p] && wr[p] && a < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (be[p][b]) m[a][b*8 +: 8] = wd[p][b*8 +: 8];
        if (be[p] == 4'hF) mk[a] = 1'b1;
      end
    end
    if (CLR && reset_n && since_rel < DEPTH) begin
      since_rel++;
      if (since_rel == DEPTH)
        for (int i = 0; i < DEPTH; i++) begin
          m[i] = 32'h0; mk[i] = 1'b1;
        end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset(input int cycles);
    idle();
    reset_n = 1'b0;
    repeat (cycles) step();
    reset_n = 1'b1;
  endtask

  task automatic wait_sweep();
    idle();
    while (CLR && since_rel < DEPTH) step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mk[i] = 1'b0;
    clken = 1'b1; reset_req = 1'b0;
    do_reset(3);
    // Reset early in the sweep; it must restart from zero.
    repeat (30) step();
    do_reset(2);
    wait_sweep();

    // Basic write then read at 0x010.
    req(0, 1'b0, 1'b1, 'h10, 4'hF, 32'hDEADBEEF); step();
    idle(); req(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0); step();
    idle(); repeat (3) step();

    // Byte lanes on @5, then four back-to-back reads.
    req(1, 1'b0, 1'b1, 5, 4'hF, 32'h11223344); step();
    req(1, 1'b0, 1'b1, 5, 4'h2, 32'hAAAAAAAA); step();
    idle();
    repeat (4) begin req(0, 1'b1, 1'b0, 5, 4'hF, 32'h0); step(); end
    idle(); repeat (3) step();

    // Write/write collision on @7: s2 stalls once, then its retry lands.
    req(0, 1'b0, 1'b1, 7, 4'hF, 32'h1);
    req(1, 1'b0, 1'b1, 7, 4'hF, 32'h2); step();
    idle(); req(1, 1'b0, 1'b1, 7, 4'hF, 32'h2); step();
    idle(); req(0, 1'b1, 1'b0, 7, 4'hF, 32'h0); step();
    idle(); repeat (3) step();

    // Read/write collision on @9: read returns the old word.
    req(0, 1'b0, 1'b1, 9, 4'hF, 32'h5); step();
    req(0, 1'b1, 1'b0, 9, 4'hF, 32'h0);
    req(1, 1'b0, 1'b1, 9, 4'hF, 32'h6); step();
    idle(); req(0, 1'b1, 1'b0, 9, 4'hF, 32'h0); step();
    idle(); repeat (3) step();

    // Out of range: write dropped, read returns 0 with valid.
    req(0, 1'b0, 1'b1, 1000, 4'hF, 32'hFFFFFFFF); step();
    idle(); req(1, 1'b1, 1'b0, 1000, 4'hF, 32'h0); step();
    req(1, 1'b1, 1'b0, 1023, 4'hF, 32'h0); step();
    idle(); repeat (3) step();

    // clken low for 3 cycles with reads in flight; new requests stall.
    req(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
    req(1, 1'b1, 1'b0, 5, 4'hF, 32'h0); step();
    clken = 1'b0;
    req(0, 1'b1, 1'b0, 9, 4'hF, 32'h0);
    req(1, 1'b0, 1'b1, 9, 4'hF, 32'h77); repeat (3) step();
    clken = 1'b1; reset_req = 1'b1; step();
    reset_req = 1'b0; idle(); repeat (3) step();

    // Randomized traffic with a reset partway through.
    for (int i = 0; i < 2000; i++) begin
      if (i == 800) begin
        req(0, 1'b1, 1'b0, 3, 4'hF, 32'h0);
        req(1, 1'b1, 1'b0, 4, 4'hF, 32'h0); step();
        do_reset(2);
        wait_sweep();
      end
      clken     = ($urandom % 16) != 0;
      reset_req = ($urandom % 20) == 0;
      for (int p = 0; p < 2; p++) begin
        cs[p]   = ($urandom % 4) != 0;
        rd[p]   = $urandom % 2;
        wr[p]   = ($urandom % 8) < 3;
        addr[p] = (($urandom % 8) == 0) ? AW'($urandom_range(990, 1023))
                                        : AW'($urandom_range(0, 15));
        be[p]   = (($urandom % 3) == 0) ? 4'(($urandom % 16)) : 4'hF;
        wd[p]   = $urandom;
      end
      step();
    end
    idle(); clken = 1'b1; reset_req = 1'b0;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
